// File: rtl/phase_seq_pkg.sv
// Shared state encoding and width helpers for the phase sequencer.
package phase_seq_pkg;

  localparam int PHASE_W = 3;

  typedef enum logic [PHASE_W-1:0] {
    ST_RST_HOLD = 3'd0,
    ST_FETCH    = 3'd1,
    ST_EXEC     = 3'd2,
    ST_MEM      = 3'd3,
    ST_WB       = 3'd4,
    ST_HALTED   = 3'd5
  } state_e;

  // Bits needed to count from 0 up to n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/phase_seq_stall_timer.sv
// Counts consecutive stalled MEM cycles and flags the cycle on which the limit is reached.
module phase_seq_stall_timer
  import phase_seq_pkg::*;
#(
  parameter int STALL_TIMEOUT = 15
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic in_mem_i,
  input  logic stall_i,
  output logic timeout_hit_o
);

  localparam int            CW   = cnt_w(STALL_TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(STALL_TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // The stalled edge that would bring the count to STALL_TIMEOUT is the hit itself.
  assign timeout_hit_o = in_mem_i && stall_i && (cnt_q == LAST);

  always_comb begin
    // NOTE: cnt_d gets a default before any branch so no latch is inferred.
    cnt_d = '0;
    if (in_mem_i && stall_i && !timeout_hit_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/phase_sequencer.sv
// FETCH/EXEC/MEM/WB enable-strobe sequencer with reset hold, stall stretch and halt/resume.
// Optional retired-instruction counter enabled by defining PHASE_SEQ_PERF_CNT_EN.
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int RESET_HOLD_CYCLES = 4,
  parameter int STALL_TIMEOUT     = 15,
  parameter int CNT_W             = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               halt_req,
  input  logic               resume,
  output logic               core_reset,
  output logic               imem_en,
  output logic               proc_en,
  output logic               dmem_en,
  output logic               regfile_en,
  output logic               halted,
  output logic               stall_timeout,
  output logic [PHASE_W-1:0] phase,
  output logic [CNT_W-1:0]   instr_count
);

  localparam int                HOLD_W    = cnt_w(RESET_HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);

  state_e            state_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic              halt_pending_q;
  logic              stall_timeout_q;
  logic              timeout_hit;

  phase_seq_stall_timer #(
    .STALL_TIMEOUT(STALL_TIMEOUT)
  ) u_stall_timer (
    .clock_i      (clock),
    .reset_i      (reset),
    .in_mem_i     (state_q == ST_MEM),
    .stall_i      (stall),
    .timeout_hit_o(timeout_hit)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= ST_RST_HOLD;
      hold_cnt_q      <= '0;
      halt_pending_q  <= 1'b0;
      stall_timeout_q <= 1'b0;
    end else begin
      if (halt_req && (state_q inside {ST_FETCH, ST_EXEC, ST_MEM})) halt_pending_q <= 1'b1;
      case (state_q)
        ST_RST_HOLD: begin
          hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
          if (hold_cnt_q == HOLD_LAST) state_q <= ST_FETCH;
        end
        ST_FETCH: state_q <= ST_EXEC;
        ST_EXEC:  state_q <= ST_MEM;
        ST_MEM: begin
          if (timeout_hit) begin
            stall_timeout_q <= 1'b1;
            state_q         <= ST_WB;
          end else if (!stall) begin
            state_q <= ST_WB;
          end
        end
        ST_WB: begin
          // A halt request arriving in WB itself still stops before the next fetch.
          if (halt_pending_q || halt_req) begin
            state_q        <= ST_HALTED;
            halt_pending_q <= 1'b0;
          end else begin
            state_q <= ST_FETCH;
          end
        end
        ST_HALTED: if (resume && !halt_req) state_q <= ST_FETCH;
        default:   state_q <= ST_RST_HOLD;
      endcase
    end
  end

  assign core_reset    = (state_q == ST_RST_HOLD);
  assign imem_en       = (state_q == ST_FETCH);
  assign proc_en       = (state_q == ST_EXEC);
  assign dmem_en       = (state_q == ST_MEM);
  assign regfile_en    = (state_q == ST_WB);
  assign halted        = (state_q == ST_HALTED);
  assign stall_timeout = stall_timeout_q;
  assign phase         = state_q;

`ifdef PHASE_SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] instr_count_q;

  always_ff @(posedge clock) begin
    if (reset)                instr_count_q <= '0;
    else if (state_q == ST_WB) instr_count_q <= instr_count_q + CNT_W'(1);
  end

  assign instr_count = instr_count_q;
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer (RESET_HOLD_CYCLES=4, STALL_TIMEOUT=8, CNT_W=4).
module tb_phase_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       stall = 1'b0;
  logic       halt_req = 1'b0;
  logic       resume = 1'b0;
  logic       core_reset, imem_en, proc_en, dmem_en, regfile_en, halted, stall_timeout;
  logic [2:0] phase;
  logic [3:0] instr_count;
  logic [4:0] ce;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  phase_sequencer #(
    .RESET_HOLD_CYCLES(4),
    .STALL_TIMEOUT    (8),
    .CNT_W            (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall),
    .halt_req     (halt_req),
    .resume       (resume),
    .core_reset   (core_reset),
    .imem_en      (imem_en),
    .proc_en      (proc_en),
    .dmem_en      (dmem_en),
    .regfile_en   (regfile_en),
    .halted       (halted),
    .stall_timeout(stall_timeout),
    .phase        (phase),
    .instr_count  (instr_count)
  );

  // {core_reset, imem_en, proc_en, dmem_en, regfile_en}
  assign ce = {core_reset, imem_en, proc_en, dmem_en, regfile_en};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) tick();
    checks++; if (ce !== 5'b10000) begin failures++; $display("FAIL reset_ce: got %b expected 10000", ce); end
    checks++; if (phase !== 3'd0) begin failures++; $display("FAIL reset_phase: got %0d expected 0", phase); end
    checks++; if ({halted, stall_timeout} !== 2'b00) begin failures++; $display("FAIL reset_flags: got %b expected 00", {halted, stall_timeout}); end
    checks++; if (instr_count !== 4'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", instr_count); end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (ce !== 5'b10000) begin failures++; $display("FAIL hold_%0d: got %b expected 10000", i, ce); end
      tick();
    end
  endtask

  task automatic test_cadence();
    logic [4:0] exp_ce;
    for (int i = 0; i < 8; i++) begin
      exp_ce = 5'b01000 >> (i % 4);
      checks++; if (ce !== exp_ce) begin failures++; $display("FAIL cadence_%0d: got %b expected %b", i, ce, exp_ce); end
      checks++; if (phase !== 3'(1 + (i % 4))) begin failures++; $display("FAIL cadence_phase_%0d: got %0d expected %0d", i, phase, 1 + (i % 4)); end
      tick();
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;  // asserted in FETCH/EXEC, where it must be ignored
    tick();
    checks++; if (ce !== 5'b00100) begin failures++; $display("FAIL stall_ignored_exec: got %b expected 00100", ce); end
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (ce !== 5'b00010) begin failures++; $display("FAIL stall_mem_%0d: got %b expected 00010", i, ce); end
      if (i == 3) stall = 1'b0;
      tick();
    end
    checks++; if (ce !== 5'b00001) begin failures++; $display("FAIL stall_wb: got %b expected 00001", ce); end
    tick();
    checks++; if (ce !== 5'b01000) begin failures++; $display("FAIL stall_fetch: got %b expected 01000", ce); end
    checks++; if (stall_timeout !== 1'b0) begin failures++; $display("FAIL stall_no_timeout: got %b expected 0", stall_timeout); end
  endtask

  task automatic test_timeout();
    tick();
    stall = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      checks++; if ({ce, stall_timeout} !== 6'b000100) begin failures++; $display("FAIL timeout_mem_%0d: got %b expected 000100", i, {ce, stall_timeout}); end
      tick();
    end
    checks++; if ({ce, stall_timeout} !== 6'b000011) begin failures++; $display("FAIL timeout_wb: got %b expected 000011", {ce, stall_timeout}); end
    tick();
    checks++; if (ce !== 5'b01000) begin failures++; $display("FAIL timeout_fetch: got %b expected 01000", ce); end
    stall = 1'b0;
    tick();
    tick();
    checks++; if (ce !== 5'b00010) begin failures++; $display("FAIL timeout_mem_after: got %b expected 00010", ce); end
    tick();
    checks++; if ({ce, stall_timeout} !== 6'b000011) begin failures++; $display("FAIL timeout_sticky: got %b expected 000011", {ce, stall_timeout}); end
    tick();
  endtask

  task automatic test_halt();
    tick();
    halt_req = 1'b1;  // one-cycle pulse during EXEC
    tick();
    halt_req = 1'b0;
    checks++; if (ce !== 5'b00010) begin failures++; $display("FAIL halt_mem: got %b expected 00010", ce); end
    tick();
    checks++; if (ce !== 5'b00001) begin failures++; $display("FAIL halt_wb: got %b expected 00001", ce); end
    tick();
    checks++; if ({ce, halted, phase} !== 9'b00000_1_101) begin failures++; $display("FAIL halt_enter: got %b expected 000001101", {ce, halted, phase}); end
    tick();
    checks++; if ({ce, halted} !== 6'b000001) begin failures++; $display("FAIL halt_stay: got %b expected 000001", {ce, halted}); end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    checks++; if ({ce, halted} !== 6'b010000) begin failures++; $display("FAIL halt_resume: got %b expected 010000", {ce, halted}); end
  endtask

  task automatic test_halt_priority();
    repeat (3) tick();
    halt_req = 1'b1;  // raised during WB itself
    tick();
    checks++; if ({ce, halted} !== 6'b000001) begin failures++; $display("FAIL prio_halted: got %b expected 000001", {ce, halted}); end
    resume = 1'b1;
    tick();
    checks++; if ({ce, halted} !== 6'b000001) begin failures++; $display("FAIL prio_hold: got %b expected 000001", {ce, halted}); end
    halt_req = 1'b0;
    tick();
    resume = 1'b0;
    checks++; if ({ce, halted} !== 6'b010000) begin failures++; $display("FAIL prio_resume: got %b expected 010000", {ce, halted}); end
    repeat (4) tick();
    checks++; if ({ce, halted} !== 6'b010000) begin failures++; $display("FAIL prio_no_pending: got %b expected 010000", {ce, halted}); end
  endtask

  task automatic test_reset_mid();
    tick();
    stall = 1'b1;
    tick();
    tick();
    checks++; if (ce !== 5'b00010) begin failures++; $display("FAIL mid_stalled: got %b expected 00010", ce); end
    reset = 1'b1;
    tick();
    checks++; if ({ce, phase} !== 8'b10000_000) begin failures++; $display("FAIL mid_reset: got %b expected 10000000", {ce, phase}); end
    checks++; if ({halted, stall_timeout} !== 2'b00) begin failures++; $display("FAIL mid_reset_flags: got %b expected 00", {halted, stall_timeout}); end
    reset = 1'b0;
    stall = 1'b0;
    repeat (4) tick();
    checks++; if (ce !== 5'b01000) begin failures++; $display("FAIL mid_restart: got %b expected 01000", ce); end
  endtask

  task automatic test_perf_count();
    logic [3:0] exp10, exp15, exp16;
`ifdef PHASE_SEQ_PERF_CNT_EN
    exp10 = 4'd10; exp15 = 4'd15; exp16 = 4'd0;
`else
    exp10 = 4'd0;  exp15 = 4'd0;  exp16 = 4'd0;
`endif
    checks++; if (instr_count !== 4'd0) begin failures++; $display("FAIL count_start: got %0d expected 0", instr_count); end
    repeat (40) tick();
    checks++; if (instr_count !== exp10) begin failures++; $display("FAIL count_10: got %0d expected %0d", instr_count, exp10); end
    repeat (20) tick();
    checks++; if (instr_count !== exp15) begin failures++; $display("FAIL count_15: got %0d expected %0d", instr_count, exp15); end
    repeat (4) tick();
    checks++; if (instr_count !== exp16) begin failures++; $display("FAIL count_wrap: got %0d expected %0d", instr_count, exp16); end
    checks++; if (ce !== 5'b01000) begin failures++; $display("FAIL count_fetch: got %b expected 01000", ce); end
  endtask

  initial begin
    test_reset();
    test_cadence();
    test_stall();
    test_timeout();
    test_halt();
    test_halt_priority();
    test_reset_mid();
    test_perf_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
